kat_adc_spi_responder: RTL and testbench

Receives the KAT ADC serial-control frames that the design drives on `kat_adc0_spi_clk`, `kat_adc0_spi_data` and `kat_adc0_spi_cs`, and decodes them into register writes. It oversamples the three SPI lines in the system clock domain and shifts in 32-bit MSB-first frames. Valid frames update a 16-entry shadow register file and raise a write strobe. The block is the responder end of the ADC control path: it serves as an ADC register model in simulation benches and as a loopback/readback monitor on the FPGA.

---
 rtl/kat_adc_spi_responder_if.sv | 26 ++
 rtl/kat_adc_spi_responder.sv | 149 ++++++++++++++
 tb/tb_kat_adc_spi_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/kat_adc_spi_responder_if.sv
// Bus bundle between a KAT ADC SPI initiator/register reader and the responder.
// wr_valid and frame_err are single-cycle pulses with no ready: the consumer must take them on the cycle they appear.
interface kat_adc_spi_responder_if;
  logic        spi_clk;
  logic        spi_data;
  logic        spi_cs;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        wr_valid;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic [15:0] frame_count;
  logic        busy;
  logic [1:0]  state_dbg;

  modport master (
    output spi_clk, spi_data, spi_cs, rd_addr,
    input  rd_data, wr_valid, wr_addr, wr_data, frame_err, frame_count, busy, state_dbg
  );

  modport slave (
    input  spi_clk, spi_data, spi_cs, rd_addr,
    output rd_data, wr_valid, wr_addr, wr_data, frame_err, frame_count, busy, state_dbg
  );
endinterface

// File: rtl/kat_adc_spi_responder.sv
// Responder end of the KAT ADC serial-control path: oversamples SPI, decodes
// 32-bit {header, addr, data} frames into a 16-entry shadow register file.
module kat_adc_spi_responder #(
  parameter logic [11:0] HEADER    = 12'h001,
  parameter logic [15:0] REG_RESET = 16'h0000
) (
  input logic clk,
  input logic rst,
  kat_adc_spi_responder_if.slave bus
);

  typedef enum logic [1:0] {
    WAIT_HIGH = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2,
    CHECK     = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        cs_s1, cs_s2, cs_prev;
  logic        clk_s1, clk_s2, clk_prev;
  logic        dat_s1, dat_s2, dat_prev;
  logic        cs_rise_q, cs_fall_q, clk_rise_q;
  logic [1:0]  settle_cnt;

  logic [31:0] shift_q;
  logic [5:0]  bit_cnt;
  logic [15:0] regs [16];

  logic        frame_ok;
  logic        start_frame;
  logic        shift_en;
  logic        accept;
  logic        reject;

  // Two-flop synchronisers, a "previous" stage, and registered edge flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_s1      <= 1'b1;
      cs_s2      <= 1'b1;
      cs_prev    <= 1'b1;
      clk_s1     <= 1'b0;
      clk_s2     <= 1'b0;
      clk_prev   <= 1'b0;
      dat_s1     <= 1'b0;
      dat_s2     <= 1'b0;
      dat_prev   <= 1'b0;
      cs_rise_q  <= 1'b0;
      cs_fall_q  <= 1'b0;
      clk_rise_q <= 1'b0;
    end else begin
      cs_s1      <= bus.spi_cs;
      cs_s2      <= cs_s1;
      cs_prev    <= cs_s2;
      clk_s1     <= bus.spi_clk;
      clk_s2     <= clk_s1;
      clk_prev   <= clk_s2;
      dat_s1     <= bus.spi_data;
      dat_s2     <= dat_s1;
      dat_prev   <= dat_s2;
      cs_rise_q  <= cs_s2 & ~cs_prev;
      cs_fall_q  <= ~cs_s2 & cs_prev;
      clk_rise_q <= clk_s2 & ~clk_prev;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= WAIT_HIGH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state. WAIT_HIGH ignores cs until the sync chain holds real samples,
  // so a frame already running at reset release is never picked up.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_HIGH: if (settle_cnt == 2'd3 && cs_s2) state_nxt = IDLE;
      IDLE:      if (cs_fall_q) state_nxt = SHIFT;
      SHIFT:     if (cs_rise_q) state_nxt = CHECK;
      CHECK:     state_nxt = IDLE;
      default:   state_nxt = WAIT_HIGH;
    endcase
  end

  // Outputs and datapath controls decoded from state.
  always_comb begin
    frame_ok      = (bit_cnt == 6'd32) && (shift_q[31:20] == HEADER);
    start_frame   = (state == IDLE) && cs_fall_q;
    shift_en      = (state == SHIFT) && clk_rise_q && !cs_rise_q;
    accept        = (state == CHECK) && frame_ok;
    reject        = (state == CHECK) && !frame_ok;
    bus.busy      = (state == SHIFT) || (state == CHECK);
    bus.state_dbg = state;
  end

  // Frame assembly; the bit counter saturates so long frames still fail the length test.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= 2'd0;
      shift_q    <= 32'd0;
      bit_cnt    <= 6'd0;
    end else begin
      if (state == WAIT_HIGH && settle_cnt != 2'd3) begin
        settle_cnt <= settle_cnt + 2'd1;
      end
      if (start_frame) begin
        shift_q <= 32'd0;
        bit_cnt <= 6'd0;
      end else if (shift_en) begin
        shift_q <= {shift_q[30:0], dat_prev};
        if (bit_cnt != 6'd63) begin
          bit_cnt <= bit_cnt + 6'd1;
        end
      end
    end
  end

  // Write-side results, shadow registers and the registered read port.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wr_valid    <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.wr_addr     <= 4'd0;
      bus.wr_data     <= 16'd0;
      bus.frame_count <= 16'd0;
      bus.rd_data     <= 16'd0;
      for (int i = 0; i < 16; i++) begin
        regs[i] <= REG_RESET;
      end
    end else begin
      bus.wr_valid  <= accept;
      bus.frame_err <= reject;
      if (accept) begin
        bus.wr_addr            <= shift_q[19:16];
        bus.wr_data            <= shift_q[15:0];
        bus.frame_count        <= bus.frame_count + 16'd1;
        regs[shift_q[19:16]]   <= shift_q[15:0];
      end
      bus.rd_data <= regs[bus.rd_addr];
    end
  end

endmodule

// File: tb/tb_kat_adc_spi_responder.sv
// Bench for kat_adc_spi_responder: SPI initiator driver, frame-level reference
// model feeding an expected queue, and a monitor checking every wr_valid/frame_err pulse.
module tb_kat_adc_spi_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  kat_adc_spi_responder_if bus();

  kat_adc_spi_responder #(
    .HEADER   (12'h001),
    .REG_RESET(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected event: {is_accept, addr, data, frame_count}
  logic [36:0] exp_q[$];
  int unsigned rise_q[$];
  logic [15:0] m_regs [16];
  logic [15:0] m_count;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
    m_count = 16'd0;
  endfunction

  // A frame is a write only when exactly 32 bits arrived and the header matches.
  function automatic void model_frame(input logic [63:0] bits, input int nbits, input int unsigned rc);
    logic [31:0] w;
    w = bits[31:0];
    if (nbits == 32 && w[31:20] == 12'h001) begin
      m_count = m_count + 16'd1;
      m_regs[w[19:16]] = w[15:0];
      exp_q.push_back({1'b1, w[19:16], w[15:0], m_count});
    end else begin
      exp_q.push_back({1'b0, 4'h0, 16'h0000, m_count});
    end
    rise_q.push_back(rc);
  endfunction

  // ---------------- driver ----------------
  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [63:0] bits, input int nbits, input int half,
                            input int gap, input bit coincide, input int rst_after);
    bit aborted;
    aborted = 1'b0;
    bus.spi_cs   = 1'b0;
    bus.spi_data = 1'b0;
    wait_cyc(half);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.spi_data = bits[i];
      wait_cyc(half);
      bus.spi_clk = 1'b1;
      wait_cyc(half);
      bus.spi_clk = 1'b0;
      if (nbits - i == rst_after) begin
        rst = 1'b1;
        wait_cyc(1);
        rst = 1'b0;
        aborted = 1'b1;
        model_reset();
      end
    end
    wait_cyc(half);
    if (!aborted) model_frame(bits, nbits, cyc);
    if (coincide) bus.spi_clk = 1'b1;
    bus.spi_cs = 1'b1;
    wait_cyc(half);
    bus.spi_clk = 1'b0;
    wait_cyc(gap);
  endtask

  task automatic drain(input string name);
    wait_cyc(10);
    check(name, exp_q.size(), 0);
  endtask

  task automatic read_reg(input logic [3:0] a);
    bus.rd_addr = a;
    wait_cyc(1);
    check($sformatf("rd_data[%0d]", a), {16'h0, bus.rd_data}, {16'h0, m_regs[a]});
  endtask

  // ---------------- monitor ----------------
  logic [36:0] mon_exp;
  logic [36:0] mon_got;
  int unsigned mon_rise;

  always @(negedge clk) begin
    if (!rst && (bus.wr_valid || bus.frame_err)) begin
      check("pulse_exclusive", {31'h0, bus.wr_valid & bus.frame_err}, 32'h0);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_pulse: got wr_valid=%0b frame_err=%0b expected none",
                 bus.wr_valid, bus.frame_err);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_rise = rise_q.pop_front();
        mon_got  = {bus.wr_valid,
                    bus.wr_valid ? bus.wr_addr : 4'h0,
                    bus.wr_valid ? bus.wr_data : 16'h0000,
                    bus.frame_count};
        if (mon_got !== mon_exp) begin
          fails++;
          $display("FAIL frame_result: got {acc,addr,data,count}=%h expected %h", mon_got, mon_exp);
        end
        check("pulse_latency", cyc - mon_rise, 32'd5);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- main sequence ----------------
  logic [31:0] w;
  logic [63:0] b;
  int nb;

  initial begin
    rst          = 1'b1;
    bus.spi_cs   = 1'b1;
    bus.spi_clk  = 1'b0;
    bus.spi_data = 1'b0;
    bus.rd_addr  = 4'd0;
    model_reset();
    wait_cyc(3);
    check("rst_wr_valid",    {31'h0, bus.wr_valid}, 32'h0);
    check("rst_frame_err",   {31'h0, bus.frame_err}, 32'h0);
    check("rst_busy",        {31'h0, bus.busy}, 32'h0);
    check("rst_frame_count", {16'h0, bus.frame_count}, 32'h0);
    check("rst_wr_addr",     {28'h0, bus.wr_addr}, 32'h0);
    check("rst_wr_data",     {16'h0, bus.wr_data}, 32'h0);
    check("rst_rd_data",     {16'h0, bus.rd_data}, 32'h0);
    rst = 1'b0;
    wait_cyc(8);

    // Good frame
    send_frame({32'h0, 12'h001, 4'h5, 16'hBEEF}, 32, 4, 3, 1'b0, -1);
    drain("drain_good");
    check("wr_addr_hold",  {28'h0, bus.wr_addr}, 32'h5);
    check("wr_data_hold",  {16'h0, bus.wr_data}, 32'hBEEF);
    check("frame_count_1", {16'h0, bus.frame_count}, 32'h1);
    read_reg(4'd5);
    read_reg(4'd0);
    read_reg(4'd6);

    // Short and long frames
    send_frame({32'h0, 12'h001, 4'h7, 16'h1111}, 31, 4, 3, 1'b0, -1);
    send_frame({31'h0, 1'b0, 12'h001, 4'h7, 16'h2222}, 33, 4, 3, 1'b0, -1);
    drain("drain_len");
    read_reg(4'd7);

    // Header mismatch
    send_frame({32'h0, 12'h000, 4'h3, 16'h1234}, 32, 4, 3, 1'b0, -1);
    drain("drain_hdr");
    read_reg(4'd3);

    // Reset after 16 bits, frame then completed by the initiator
    send_frame({32'h0, 12'h001, 4'h9, 16'h7777}, 32, 4, 3, 1'b0, 16);
    drain("drain_abort");
    send_frame({32'h0, 12'h001, 4'hA, 16'h00FF}, 32, 4, 3, 1'b0, -1);
    drain("drain_after_abort");
    check("frame_count_after_rst", {16'h0, bus.frame_count}, 32'h1);
    read_reg(4'd9);
    read_reg(4'd10);

    // Back-to-back with minimum cs-high gap
    send_frame({32'h0, 12'h001, 4'h1, 16'hAAAA}, 32, 3, 0, 1'b0, -1);
    send_frame({32'h0, 12'h001, 4'h2, 16'h5555}, 32, 4, 3, 1'b0, -1);
    drain("drain_b2b");
    check("frame_count_b2b", {16'h0, bus.frame_count}, 32'h3);
    read_reg(4'd1);
    read_reg(4'd2);

    // Final cs rise coincides with an extra spi_clk rise
    send_frame({32'h0, 12'h001, 4'hC, 16'hC0DE}, 32, 4, 3, 1'b1, -1);
    drain("drain_coincide");
    read_reg(4'd12);

    // Randomized frames
    for (int n = 0; n < 14; n++) begin
      w[31:20] = ($urandom_range(0, 3) == 0) ? 12'($urandom) : 12'h001;
      w[19:16] = 4'($urandom);
      w[15:0]  = 16'($urandom);
      case ($urandom_range(0, 4))
        0:       nb = 31;
        1:       nb = 33;
        default: nb = 32;
      endcase
      b = {31'h0, 1'($urandom), w};
      send_frame(b, nb, $urandom_range(3, 6), $urandom_range(0, 3), 1'($urandom), -1);
    end
    drain("drain_random");

    for (int a = 0; a < 16; a++) read_reg(4'(a));
    check("frame_count_final", {16'h0, bus.frame_count}, {16'h0, m_count});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
